// File: rtl/intr_ctrl.sv
// intr_ctrl: edge-detecting, maskable interrupt controller with one prioritised request to the CPU (round-robin when INTC_PRIO_ROTATE_EN is defined, else fixed lowest-index)
module intr_ctrl #(
    parameter int NSRC    = 4,
    parameter int VECW    = 2,
    parameter int datawid = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cs,
    input  logic               wr,
    input  logic               rd,
    input  logic [1:0]         addr,
    input  logic [datawid-1:0] datain,
    output logic [datawid-1:0] dataout,
    input  logic [NSRC-1:0]    src,
    output logic               irq,
    output logic [VECW-1:0]    irq_vec,
    input  logic               irq_ack
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    state_t state_q, state_d;
    logic [NSRC-1:0] src_q, pend_q, pend_d, en_q, en_d, rise, req;
    logic irq_q, irq_d;
    logic [VECW-1:0] vec_q, vec_d, win;
    logic [datawid-1:0] dout_q, dout_d;
    logic wr_en, rd_en;
`ifdef INTC_PRIO_ROTATE_EN
    logic [VECW-1:0] last_q, last_d;
    logic [2*NSRC-1:0] dbl;
`endif
    assign wr_en = cs & wr;
    assign rd_en = cs & rd;
    assign rise = src & ~src_q;
    assign req = pend_q & en_q;
    assign irq = irq_q;
    assign irq_vec = vec_q;
    assign dataout = dout_q;
`ifdef INTC_PRIO_ROTATE_EN
    // winner search starts just after the last serviced source, wrapping around
    always_comb begin
        win = '0;
        dbl = {req, req} >> (int'(last_q) + 1);
        for (int i = NSRC - 1; i >= 0; i--)
            if (dbl[i]) win = VECW'((int'(last_q) + 1 + i) % NSRC);
    end
`else
    // fixed priority: lowest active index wins
    always_comb begin
        win = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (req[i]) win = VECW'(i);
    end
`endif
    // register file: enable writes, pending set/clear (rise > ack > W1C), read data capture
    always_comb begin
        en_d = en_q;
        pend_d = pend_q;
        dout_d = dout_q;
        if (wr_en && addr == 2'd0) en_d = datain[NSRC-1:0];
        if (wr_en && addr == 2'd1) pend_d = pend_d & ~datain[NSRC-1:0];
        if (state_q == REQ && irq_ack) pend_d = pend_d & ~(NSRC'(1) << vec_q);
        pend_d = pend_d | rise;
        if (rd_en)
            dout_d = addr == 2'd0 ? datawid'(en_q) :
                     addr == 2'd1 ? datawid'(pend_q) :
                     addr == 2'd2 ? datawid'({state_q == REQ, vec_q}) : '0;
    end
    // request FSM: grant from IDLE, hold through REQ until ack, one low cycle in GAP
    always_comb begin
        state_d = state_q;
        irq_d = irq_q;
        vec_d = vec_q;
`ifdef INTC_PRIO_ROTATE_EN
        last_d = last_q;
`endif
        case (state_q)
            IDLE: if (|req) begin
                vec_d = win;
                irq_d = 1'b1;
                state_d = REQ;
            end
            REQ: if (irq_ack) begin
                irq_d = 1'b0;
`ifdef INTC_PRIO_ROTATE_EN
                last_d = vec_q;
`endif
                state_d = GAP;
            end
            default: state_d = IDLE;
        endcase
    end
    // state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            src_q <= '0;
            pend_q <= '0;
            en_q <= '0;
            irq_q <= 1'b0;
            vec_q <= '0;
            dout_q <= '0;
`ifdef INTC_PRIO_ROTATE_EN
            last_q <= VECW'(NSRC - 1);
`endif
        end else begin
            state_q <= state_d;
            src_q <= src;
            pend_q <= pend_d;
            en_q <= en_d;
            irq_q <= irq_d;
            vec_q <= vec_d;
            dout_q <= dout_d;
`ifdef INTC_PRIO_ROTATE_EN
            last_q <= last_d;
`endif
        end
    end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: randomized and directed scoreboard bench for intr_ctrl against a behavioural model
module tb_intr_ctrl;
    localparam int N = 4, VW = 2, DW = 16;
    logic clk = 0, rst_n = 0, cs = 0, wr = 0, rd = 0, irq_ack = 0;
    logic [1:0] addr = 0;
    logic [DW-1:0] datain = 0;
    logic [N-1:0] src = 0;
    logic [DW-1:0] dataout;
    logic irq;
    logic [VW-1:0] irq_vec;
    intr_ctrl #(.NSRC(N), .VECW(VW), .datawid(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
        .datain(datain), .dataout(dataout), .src(src), .irq(irq),
        .irq_vec(irq_vec), .irq_ack(irq_ack)
    );
    always #5 clk = ~clk;
    int total = 0, bad = 0;
    int vq[$];
    logic [DW-1:0] rq[$];
    logic [N-1:0] m_pend, m_en, m_srcq;
    int m_state, m_vec, m_last;
    bit m_irq, irq_prev = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int winner(input logic [N-1:0] r, input int last);
`ifdef INTC_PRIO_ROTATE_EN
        for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`else
        for (int i = 0; i < N; i++) if (r[i]) return i;
`endif
        return 0;
    endfunction
    task automatic mreset();
        m_pend = 0; m_en = 0; m_srcq = 0; m_state = 0; m_vec = 0; m_last = N - 1; m_irq = 0;
        vq.delete(); rq.delete();
    endtask
    // drive one cycle of inputs and advance the model across the coming edge
    task automatic step(input logic [N-1:0] s, input logic c, input logic w, input logic r,
                        input logic [1:0] a, input logic [DW-1:0] d, input logic ack);
        logic [N-1:0] rise, rq_v, np;
        @(negedge clk);
        src = s; cs = c; wr = w; rd = r; addr = a; datain = d; irq_ack = ack;
        rise = s & ~m_srcq;
        rq_v = m_pend & m_en;
        np = m_pend;
        if (c && r)
            rq.push_back(a == 0 ? DW'(m_en) : a == 1 ? DW'(m_pend) :
                         a == 2 ? DW'({m_state == 1, VW'(m_vec)}) : '0);
        if (c && w && a == 1) np &= ~d[N-1:0];
        if (m_state == 1 && ack) np[m_vec] = 1'b0;
        np |= rise;
        if (c && w && a == 0) m_en = d[N-1:0];
        if (m_state == 0) begin
            if (|rq_v) begin
                m_vec = winner(rq_v, m_last);
                vq.push_back(m_vec);
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (ack) begin
                m_last = m_vec;
                m_state = 2;
            end
        end else m_state = 0;
        m_pend = np;
        m_srcq = s;
        m_irq = (m_state == 1);
        @(posedge clk);
    endtask
    task automatic tick(); step(src, 0, 0, 0, 0, 0, 0); endtask
    task automatic wreg(input logic [1:0] a, input logic [DW-1:0] d); step(src, 1, 1, 0, a, d, 0); endtask
    task automatic rreg(input logic [1:0] a); step(src, 1, 0, 1, a, 0, 0); endtask
    task automatic wait_ack(input logic [N-1:0] s);
        int n = 0;
        while (!m_irq && n < 10) begin tick(); n++; end
        step(s, 0, 0, 0, 0, 0, 1);
    endtask
    // monitor: compares DUT outputs with the model and scoreboard queues just after each edge
    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n) begin
            check("irq", irq, m_irq);
            if (irq && !irq_prev) begin
                if (vq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL vec: unexpected request vec=%0d", irq_vec);
                end else check("vec", irq_vec, vq.pop_front());
            end
            if (cs && rd) begin
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rdata: unexpected read got %0h", dataout);
                end else check("rdata", dataout, rq.pop_front());
            end
        end
        irq_prev = irq;
    end
    initial begin
        mreset();
        #1;
        check("rst_irq", irq, 0);
        check("rst_vec", irq_vec, 0);
        check("rst_dout", dataout, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        // single source, held high: one request only
        wreg(0, 16'h1);
        step(4'h1, 0, 0, 0, 0, 0, 0);
        rreg(1);
        wait_ack(4'h1);
        repeat (20) tick();
        rreg(1);
        step(4'h0, 0, 0, 0, 0, 0, 0);
        // masked source pends, then enable releases it
        wreg(0, 16'h0);
        step(4'h4, 0, 0, 0, 0, 0, 0);
        step(4'h0, 0, 0, 0, 0, 0, 0);
        rreg(1);
        wreg(0, 16'h4);
        wait_ack(4'h0);
        rreg(1);
        // simultaneous rises: arbitration order and back-to-back spacing
        wreg(0, 16'hF);
        step(4'hA, 0, 0, 0, 0, 0, 0);
        step(4'h0, 0, 0, 0, 0, 0, 0);
        wait_ack(4'h0);
        rreg(2);
        wait_ack(4'h0);
        repeat (3) tick();
        // W1C and mask while in REQ do not drop the request
        step(4'h1, 0, 0, 0, 0, 0, 0);
        step(4'h0, 0, 0, 0, 0, 0, 0);
        tick();
        rreg(2);
        wreg(1, 16'h1);
        wreg(0, 16'h0);
        repeat (3) tick();
        wait_ack(4'h0);
        repeat (5) tick();
        // rise on the ack cycle keeps the source pending
        wreg(0, 16'h1);
        step(4'h1, 0, 0, 0, 0, 0, 0);
        step(4'h0, 0, 0, 0, 0, 0, 0);
        wait_ack(4'h1);
        step(4'h0, 0, 0, 0, 0, 0, 0);
        wait_ack(4'h0);
        repeat (3) tick();
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic w, r;
            w = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 3) == 0);
            step(N'($urandom), w | r, w, r, 2'($urandom), DW'($urandom),
                 m_irq ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0));
        end
        // asynchronous reset in the middle of a request
        wreg(0, 16'hF);
        rreg(0);
        step(4'h0, 0, 0, 0, 0, 0, 0);
        step(4'h2, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        check("pre_rst_irq", irq, 1);
        @(negedge clk);
        #2;
        rst_n = 0;
        src = 0;
        mreset();
        #1;
        check("arst_irq", irq, 0);
        check("arst_dout", dataout, 0);
        check("arst_vec", irq_vec, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        rreg(1);
        rreg(0);
        repeat (3) tick();
        check("vq_empty", vq.size(), 0);
        check("rq_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
